// File: rtl/volleyball_pkg.sv
// Shared definitions for the volleyball match controller: FSM encoding,
// counter point-target modes and team identifiers.
package volleyball_pkg;

   typedef enum logic [1:0] {
      PLAY       = 2'd0,
      SET_DONE   = 2'd1,
      CLEAR      = 2'd2,
      MATCH_DONE = 2'd3
   } match_state_t;

   localparam logic MODE_25 = 1'b1;
   localparam logic MODE_15 = 1'b0;

   localparam logic TEAM_A = 1'b0;
   localparam logic TEAM_B = 1'b1;

endpackage

// File: rtl/volleyball_match_ctrl_rise_detect.sv
// 1-bit synchronous rising-edge detector: rise is high for the cycle in
// which d is high and was low on the previous clock.
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic prev_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_reg <= 1'b0;
      end else begin
         prev_reg <= d;
      end
   end

   assign rise = d & ~prev_reg;

endmodule

// File: rtl/volleyball_match_ctrl.sv
// Match controller: tallies sets from the score counters' set-win levels,
// sequences set changes and declares the winner. SET_HISTORY_EN adds a set-winner log.
module volleyball_match_ctrl
   import volleyball_pkg::*;
#(
   parameter int SETS_TO_WIN = 3,
   parameter int SET_W       = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_set_win,
   input  logic             b_set_win,
   input  logic             next_set,
   output logic [SET_W-1:0] sets_a,
   output logic [SET_W-1:0] sets_b,
   output logic [SET_W-1:0] set_num,
   output logic             mode,
   output logic             score_clr,
   output logic             set_over,
   output logic             match_over,
   output logic             winner
`ifdef SET_HISTORY_EN
   ,
   output logic [2*SETS_TO_WIN-2:0] set_hist,
   output logic [SET_W-1:0]         hist_len
`endif
);

   localparam logic [SET_W-1:0] ONE    = SET_W'(1);
   localparam logic [SET_W-1:0] TARGET = SET_W'(SETS_TO_WIN);
   localparam logic [SET_W-1:0] TIE    = SET_W'(SETS_TO_WIN - 1);

   match_state_t     state_reg;
   logic [SET_W-1:0] sets_a_reg;
   logic [SET_W-1:0] sets_b_reg;
   logic [SET_W-1:0] set_num_reg;
   logic             mode_reg;
   logic             score_clr_reg;
   logic             set_over_reg;
   logic             match_over_reg;
   logic             winner_reg;

   logic [1:0]       set_win_lvl;
   logic [1:0]       win_edge;
   logic             win_a;
   logic             win_b;
   logic             credit;
   logic [SET_W-1:0] sets_a_next;
   logic [SET_W-1:0] sets_b_next;
   logic             reach_target;

   assign set_win_lvl = {b_set_win, a_set_win};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_edge
         rise_detect u_rise (
            .clk  (clk),
            .rst  (rst),
            .d    (set_win_lvl[gi]),
            .rise (win_edge[gi])
         );
      end
   endgenerate

   assign win_a = win_edge[0];
   assign win_b = win_edge[1];

   // A simultaneous double edge is ambiguous and earns neither team a set.
   assign credit       = (state_reg == PLAY) && (win_a ^ win_b);
   assign sets_a_next  = sets_a_reg + ONE;
   assign sets_b_next  = sets_b_reg + ONE;
   assign reach_target = win_b ? (sets_b_next == TARGET) : (sets_a_next == TARGET);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= PLAY;
         sets_a_reg     <= '0;
         sets_b_reg     <= '0;
         set_num_reg    <= ONE;
         mode_reg       <= MODE_25;
         score_clr_reg  <= 1'b0;
         set_over_reg   <= 1'b0;
         match_over_reg <= 1'b0;
         winner_reg     <= TEAM_A;
      end else begin
         case (state_reg)
            PLAY: begin
               if (credit) begin
                  if (win_b) begin
                     sets_b_reg <= sets_b_next;
                     winner_reg <= TEAM_B;
                  end else begin
                     sets_a_reg <= sets_a_next;
                     winner_reg <= TEAM_A;
                  end
                  if (reach_target) begin
                     state_reg      <= MATCH_DONE;
                     match_over_reg <= 1'b1;
                  end else begin
                     state_reg    <= SET_DONE;
                     set_over_reg <= 1'b1;
                  end
               end
            end
            SET_DONE: begin
               if (next_set) begin
                  state_reg     <= CLEAR;
                  score_clr_reg <= 1'b1;
                  set_over_reg  <= 1'b0;
               end
            end
            CLEAR: begin
               // New set number and point target land as score_clr drops.
               state_reg     <= PLAY;
               score_clr_reg <= 1'b0;
               set_num_reg   <= set_num_reg + ONE;
               mode_reg      <= ((sets_a_reg == TIE) && (sets_b_reg == TIE)) ? MODE_15 : MODE_25;
            end
            MATCH_DONE: begin
               state_reg <= MATCH_DONE;
            end
            default: begin
               state_reg <= PLAY;
            end
         endcase
      end
   end

   assign sets_a     = sets_a_reg;
   assign sets_b     = sets_b_reg;
   assign set_num    = set_num_reg;
   assign mode       = mode_reg;
   assign score_clr  = score_clr_reg;
   assign set_over   = set_over_reg;
   assign match_over = match_over_reg;
   assign winner     = winner_reg;

`ifdef SET_HISTORY_EN
   logic [2*SETS_TO_WIN-2:0] set_hist_reg;
   logic [SET_W-1:0]         hist_len_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         hist_len_reg <= '0;
      end else if (credit) begin
         hist_len_reg <= hist_len_reg + ONE;
      end
   end

   // Each credited set writes its winner into the slot addressed by hist_len.
   generate
      for (genvar gi = 0; gi < 2*SETS_TO_WIN-1; gi++) begin : g_hist
         always_ff @(posedge clk) begin
            if (rst) begin
               set_hist_reg[gi] <= 1'b0;
            end else if (credit && (hist_len_reg == SET_W'(gi))) begin
               set_hist_reg[gi] <= win_b;
            end
         end
      end
   endgenerate

   assign set_hist = set_hist_reg;
   assign hist_len = hist_len_reg;
`endif

endmodule

// File: tb/tb_volleyball_match_ctrl.sv
// Directed self-checking bench for volleyball_match_ctrl (SETS_TO_WIN=3).
module tb_volleyball_match_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       a_set_win = 1'b0;
   logic       b_set_win = 1'b0;
   logic       next_set = 1'b0;
   logic [2:0] sets_a;
   logic [2:0] sets_b;
   logic [2:0] set_num;
   logic       mode;
   logic       score_clr;
   logic       set_over;
   logic       match_over;
   logic       winner;
`ifdef SET_HISTORY_EN
   logic [4:0] set_hist;
   logic [2:0] hist_len;
`endif

   int errors = 0;
   int checks = 0;

   volleyball_match_ctrl #(.SETS_TO_WIN(3), .SET_W(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .a_set_win  (a_set_win),
      .b_set_win  (b_set_win),
      .next_set   (next_set),
      .sets_a     (sets_a),
      .sets_b     (sets_b),
      .set_num    (set_num),
      .mode       (mode),
      .score_clr  (score_clr),
      .set_over   (set_over),
      .match_over (match_over),
      .winner     (winner)
`ifdef SET_HISTORY_EN
      ,
      .set_hist   (set_hist),
      .hist_len   (hist_len)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Raise one team's set-win level for a cycle, then drop it.
   task automatic win_set(input bit team_b);
      if (team_b) b_set_win = 1'b1; else a_set_win = 1'b1;
      tick();
      a_set_win = 1'b0;
      b_set_win = 1'b0;
   endtask

   // next_set pulse, then the CLEAR cycle; leaves the DUT back in PLAY.
   task automatic advance();
      next_set = 1'b1;
      tick();
      next_set = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, " sets_a"}, sets_a, 0);
      check({pfx, " sets_b"}, sets_b, 0);
      check({pfx, " set_num"}, set_num, 1);
      check({pfx, " mode"}, mode, 1);
      check({pfx, " score_clr"}, score_clr, 0);
      check({pfx, " set_over"}, set_over, 0);
      check({pfx, " match_over"}, match_over, 0);
      check({pfx, " winner"}, winner, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // 1. reset then idle
      do_reset();
      check_reset_vals("reset");
      tick();
      check("idle set_over", set_over, 0);
      check("idle sets_a", sets_a, 0);

      // 2 + 4. A wins with its level held high through SET_DONE and CLEAR
      a_set_win = 1'b1;
      tick();
      check("a1 sets_a", sets_a, 1);
      check("a1 set_over", set_over, 1);
      check("a1 winner", winner, 0);
      check("a1 match_over", match_over, 0);
      next_set = 1'b1;
      tick();
      next_set = 1'b0;
      check("clr1 score_clr", score_clr, 1);
      check("clr1 set_over", set_over, 0);
      tick();
      check("play2 score_clr", score_clr, 0);
      check("play2 set_num", set_num, 2);
      check("play2 mode", mode, 1);
      tick();
      tick();
      check("held sets_a", sets_a, 1);
      check("held set_over", set_over, 0);
      a_set_win = 1'b0;
      tick();

      // simultaneous edges are ignored
      a_set_win = 1'b1;
      b_set_win = 1'b1;
      tick();
      check("simul sets_a", sets_a, 1);
      check("simul sets_b", sets_b, 0);
      check("simul set_over", set_over, 0);
      a_set_win = 1'b0;
      b_set_win = 1'b0;
      tick();

      // 3. B, A, B to reach 2-2, then deciding set
      win_set(1'b1);
      check("b1 sets_b", sets_b, 1);
      check("b1 winner", winner, 1);
      advance();
      check("set3 set_num", set_num, 3);
      check("set3 mode", mode, 1);
      win_set(1'b0);
      check("a2 sets_a", sets_a, 2);
      advance();
      check("set4 set_num", set_num, 4);
      check("set4 mode", mode, 1);
      win_set(1'b1);
      check("b2 sets_b", sets_b, 2);
      check("b2 set_over", set_over, 1);
      advance();
      check("set5 set_num", set_num, 5);
      check("set5 mode", mode, 0);
      win_set(1'b1);
      check("match sets_b", sets_b, 3);
      check("match match_over", match_over, 1);
      check("match winner", winner, 1);
      check("match set_over", set_over, 0);

      // next_set and win edges in MATCH_DONE are ignored
      next_set = 1'b1;
      tick();
      next_set = 1'b0;
      check("md score_clr", score_clr, 0);
      check("md set_num", set_num, 5);
      win_set(1'b0);
      tick();
      check("md sets_a", sets_a, 2);
      check("md match_over", match_over, 1);
      check("md mode", mode, 0);

      // 5. reset during CLEAR at 2-1
      do_reset();
      win_set(1'b0);
      advance();
      win_set(1'b1);
      advance();
      win_set(1'b0);
      check("21 sets_a", sets_a, 2);
      check("21 sets_b", sets_b, 1);
      next_set = 1'b1;
      tick();
      next_set = 1'b0;
      check("21 clr score_clr", score_clr, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_vals("midrst");
`ifdef SET_HISTORY_EN
      check("midrst hist_len", hist_len, 0);
      check("midrst set_hist", set_hist, 0);
`endif
      tick();
      check("post rst set_num", set_num, 1);

      // 6. A,B,B,A,A
      do_reset();
      win_set(1'b0);
      advance();
      win_set(1'b1);
      advance();
      win_set(1'b1);
      advance();
      win_set(1'b0);
      advance();
      check("hseq set_num", set_num, 5);
      check("hseq mode", mode, 0);
      win_set(1'b0);
      check("hseq sets_a", sets_a, 3);
      check("hseq sets_b", sets_b, 2);
      check("hseq match_over", match_over, 1);
      check("hseq winner", winner, 0);
`ifdef SET_HISTORY_EN
      check("hseq set_hist", set_hist, 5'b00110);
      check("hseq hist_len", hist_len, 5);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
